spi_readout_ctrl: RTL

- SPI slave front-end (mode 0, MSB-first) that sequences the 8-byte capture memory holding the 16-bit F/C/L/R timing words out to the host MCU.
- Oversamples SS/SCK/MOSI in the system clock domain and drives the memory's reset_addr/incr controls.
- Shifts each memory byte out on MISO and returns MOSI bytes to the fabric.
- Pulses a snapshot request at frame start so the F/C/L/R values stay coherent for the whole transfer.

---
 rtl/spi_readout_ctrl_pkg.sv | 14 +
 rtl/spi_readout_ctrl_if.sv | 30 +++
 rtl/spi_readout_ctrl_sync_edge.sv | 31 +++
 rtl/spi_readout_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/spi_readout_ctrl_pkg.sv
// Shared types and constants for the SPI readout controller.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RST_ADDR,
        LOAD,
        SHIFT
    } state_t;

    localparam int unsigned SPI_BITS    = 8;
    localparam int unsigned FRAME_BYTES = 8;

endpackage

// File: rtl/spi_readout_ctrl_if.sv
// SPI pins, capture-memory controls and receive/status signals of the readout controller.
interface spi_readout_ctrl_if;

    logic       ss_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] mem_byte;
    logic       mem_reset_addr;
    logic       mem_incr;
    logic       snap_req;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [3:0] byte_cnt;
    logic       busy;

    modport slave (
        input  ss_n, sck, mosi, mem_byte,
        output miso, miso_oe, mem_reset_addr, mem_incr, snap_req,
               rx_byte, rx_valid, byte_cnt, busy
    );

    modport master (
        output ss_n, sck, mosi, mem_byte,
        input  miso, miso_oe, mem_reset_addr, mem_incr, snap_req,
               rx_byte, rx_valid, byte_cnt, busy
    );

endinterface

// File: rtl/spi_readout_ctrl_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              dly;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            dly  <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~dly;
    assign fall  = ~level & dly;

endmodule

// File: rtl/spi_readout_ctrl.sv
// Mode-0 SPI slave that streams the capture memory out on MISO and returns MOSI bytes.
module spi_readout_ctrl
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LENGTH      = 8
) (
    input  logic            clk,
    input  logic            rst,
    spi_readout_ctrl_if.slave bus
);

    localparam logic [3:0] BIT_LAST = 4'(SPI_BITS - 1);
    localparam logic [3:0] BIT_DONE = 4'(SPI_BITS);

    if (SYNC_STAGES < 2 || LENGTH != FRAME_BYTES) begin : g_bad_param
        $error("spi_readout_ctrl: SYNC_STAGES must be >= 2 and LENGTH must equal FRAME_BYTES");
    end

    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic sck_s, ss_s;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .rst(rst), .din(bus.sck),
        .level(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
        .clk(clk), .rst(rst), .din(bus.ss_n),
        .level(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) mosi_sync <= '0;
        else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    state_t     state, state_n;
    logic [7:0] tx_shift, tx_shift_n, rx_shift, rx_shift_n, rx_byte, rx_byte_n;
    logic [3:0] bit_cnt, bit_cnt_n, byte_cnt, byte_cnt_n;
    logic       miso, miso_n, rx_valid, rx_valid_n;
    logic       reset_addr, incr, snap, load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            miso     <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_n;
            tx_shift <= tx_shift_n;
            rx_shift <= rx_shift_n;
            rx_byte  <= rx_byte_n;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            miso     <= miso_n;
            rx_valid <= rx_valid_n;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n    = state;
        tx_shift_n = tx_shift;
        rx_shift_n = rx_shift;
        rx_byte_n  = rx_byte;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        miso_n     = miso;
        rx_valid_n = 1'b0;
        reset_addr = 1'b0;
        incr       = 1'b0;
        snap       = 1'b0;
        load       = 1'b0;

        // Deselect wins over any coincident SCK edge and suppresses all memory pulses.
        if (state != IDLE && ss_rise) begin
            state_n = IDLE;
            miso_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    miso_n = 1'b0;
                    if (ss_fall) state_n = RST_ADDR;
                end
                RST_ADDR: begin
                    reset_addr = 1'b1;
                    snap       = 1'b1;
                    byte_cnt_n = '0;
                    state_n    = LOAD;
                end
                LOAD: begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
                SHIFT: begin
                    if (sck_rise) begin
                        rx_shift_n = {rx_shift[6:0], mosi_s};
                        bit_cnt_n  = bit_cnt + 4'd1;
                        if (bit_cnt == BIT_LAST) begin
                            rx_byte_n  = {rx_shift[6:0], mosi_s};
                            rx_valid_n = 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt == BIT_DONE) begin
                            load = 1'b1;
                        end else begin
                            tx_shift_n = {tx_shift[6:0], 1'b0};
                            miso_n     = tx_shift[6];
                        end
                    end
                end
                default: state_n = IDLE;
            endcase

            if (load) begin
                tx_shift_n = bus.mem_byte;
                miso_n     = bus.mem_byte[7];
                incr       = 1'b1;
                bit_cnt_n  = '0;
                byte_cnt_n = (byte_cnt == 4'd15) ? byte_cnt : byte_cnt + 4'd1;
            end
        end
    end

    assign bus.miso           = miso;
    assign bus.miso_oe        = (state != IDLE);
    assign bus.busy           = (state != IDLE);
    assign bus.mem_reset_addr = reset_addr;
    assign bus.mem_incr       = incr;
    assign bus.snap_req       = snap;
    assign bus.rx_byte        = rx_byte;
    assign bus.rx_valid       = rx_valid;
    assign bus.byte_cnt       = byte_cnt;

endmodule
